// File: rtl/dmem_access_stage.sv
// Memory stage between X/M and M/W: passes non-memory ops straight through and runs a
// req/gnt/rvalid handshake for lw/sw, stalling upstream and bubbling M/W until it completes.
module dmem_access_stage #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       in_ir,
  input  logic [31:0]       in_O,
  input  logic [31:0]       in_B,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       mw_ir,
  output logic [31:0]       mw_O,
  output logic [31:0]       mw_D,
  output logic              stall,
  output logic              err
);

  localparam logic [4:0] OpLw = 5'b01000;
  localparam logic [4:0] OpSw = 5'b00111;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      o_q, o_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             abort_q, abort_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic        is_mem;
  logic        timeout;
  logic        req_c, stall_c, err_c;
  logic [31:0] mw_ir_c, mw_o_c, mw_d_c;

  assign is_mem  = (in_ir[31:27] == OpLw) || (in_ir[31:27] == OpSw);
  assign timeout = (cnt_q == TMO_W'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    o_d     = o_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    err_c   = 1'b0;
    mw_ir_c = 32'h0;
    mw_o_c  = 32'h0;
    mw_d_c  = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          ir_d    = in_ir;
          o_d     = in_O;
          b_d     = in_B;
          we_d    = (in_ir[31:27] == OpSw);
          rdata_d = 32'h0;
          abort_d = 1'b0;
          cnt_d   = '0;
          stall_c = 1'b1;
          state_d = StReq;
        end else begin
          mw_ir_c = in_ir;
          mw_o_c  = in_O;
        end
      end
      StReq: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // A grant in the timeout cycle still wins over the abort.
        if (dmem_gnt) begin
          state_d = we_q ? StDone : StWait;
        end else if (timeout) begin
          abort_d = 1'b1;
          state_d = StDone;
        end
      end
      StWait: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = StDone;
        end else if (timeout) begin
          abort_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // X/M still holds the op just retired, so in_ir is not decoded here.
        mw_ir_c = ir_q;
        mw_o_c  = o_q;
        mw_d_c  = (we_q || abort_q) ? 32'h0 : rdata_q;
        err_c   = abort_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ir_q    <= 32'h0;
      o_q     <= 32'h0;
      b_q     <= 32'h0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      o_q     <= o_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces every output low immediately, independent of the clock.
  assign dmem_req   = reset & req_c;
  assign dmem_we    = reset & we_q;
  assign dmem_addr  = {ADDR_W{reset}} & o_q[ADDR_W-1:0];
  assign dmem_wdata = {32{reset}} & b_q;
  assign mw_ir      = {32{reset}} & mw_ir_c;
  assign mw_O       = {32{reset}} & mw_o_c;
  assign mw_D       = {32{reset}} & mw_d_c;
  assign stall      = reset & stall_c;
  assign err        = reset & err_c;

endmodule

// File: tb/tb_dmem_access_stage.sv
// Randomized bench for dmem_access_stage: a transaction-level model predicts every cycle of
// each instruction from its planned gnt/rvalid delays; literal checks pin the directed cases.
module tb_dmem_access_stage;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 4;
  localparam logic [4:0]  LW  = 5'b01000;
  localparam logic [4:0]  SW  = 5'b00111;
  localparam logic [31:0] ADD_IR = 32'h0800_1234;
  localparam logic [31:0] LW_IR  = 32'h4012_3456;
  localparam logic [31:0] SW_IR  = 32'h3812_3456;

  logic          clock, reset;
  logic [31:0]   in_ir, in_O, in_B;
  logic          dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic [31:0]   mw_ir, mw_O, mw_D;
  logic          stall, err;

  dmem_access_stage #(.ADDR_W(AW), .TMO_W(8), .MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .in_ir(in_ir), .in_O(in_O), .in_B(in_B),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mw_ir(mw_ir), .mw_O(mw_O), .mw_D(mw_D), .stall(stall), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs for the current cycle, written by the driver.
  logic          chk_en = 1'b0;
  logic [31:0]   e_ir, e_o, e_d, e_wdata;
  logic          e_stall, e_err, e_req, e_we;
  logic [AW-1:0] e_addr;

  // Observations accumulated from the DUT for the directed literal checks.
  int            obs_stall = 0, obs_req = 0, obs_err = 0, obs_retire = 0;
  logic [31:0]   obs_last_d = 0, obs_last_ir = 0, obs_last_wdata = 0;
  logic [AW-1:0] obs_last_addr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("mw_ir", mw_ir, e_ir);
      chk("mw_O", mw_O, e_o);
      chk("mw_D", mw_D, e_d);
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("err", {31'b0, err}, {31'b0, e_err});
      chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
      if (e_req) begin
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
        chk("dmem_addr", {20'b0, dmem_addr}, {20'b0, e_addr});
        chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (stall) obs_stall++;
      if (err) obs_err++;
      if (dmem_req) begin
        obs_req++;
        obs_last_addr  = dmem_addr;
        obs_last_wdata = dmem_wdata;
      end
      if (!stall) begin
        obs_last_d  = mw_D;
        obs_last_ir = mw_ir;
        if (mw_ir[31:27] == LW || mw_ir[31:27] == SW) obs_retire++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_bubble(input logic req, input logic we, input logic [31:0] o,
                            input logic [31:0] b);
    e_ir = 0; e_o = 0; e_d = 0; e_stall = 1; e_err = 0;
    e_req = req; e_we = we; e_addr = o[AW-1:0]; e_wdata = b;
  endtask

  // One instruction from its first IDLE cycle through retirement. g = REQ cycles before gnt,
  // r = WAIT cycles before rvalid; the timeout fires when REQ+WAIT reaches cycle index TMO.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                        input int g, input int r, input bit fix, input logic [31:0] fix_d);
    bit          mem, is_lw, granted, abort;
    int          k, j;
    logic [31:0] d, rv;
    mem   = (ir[31:27] == LW) || (ir[31:27] == SW);
    is_lw = (ir[31:27] == LW);
    in_ir = ir; in_O = o; in_B = b;
    dmem_gnt = 0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    if (!mem) begin
      e_ir = ir; e_o = o; e_d = 0; e_stall = 0; e_err = 0; e_req = 0; e_we = 0;
      e_addr = 0; e_wdata = 0;
      step();
      return;
    end
    exp_bubble(0, !is_lw, o, b);
    step();
    k = 0; granted = 0; abort = 0; d = 0;
    forever begin
      dmem_gnt    = (k == g);
      dmem_rvalid = (k != int'(TMO)) ? 1'($urandom_range(0, 1)) : 1'b0;
      dmem_rdata  = $urandom;
      exp_bubble(1, !is_lw, o, b);
      step();
      if (k == g) begin granted = 1; k++; break; end
      if (k == int'(TMO)) begin abort = 1; k++; break; end
      k++;
    end
    if (is_lw && granted) begin
      j = 0;
      forever begin
        rv = fix ? fix_d : $urandom;
        dmem_gnt = 0; dmem_rvalid = (j == r); dmem_rdata = rv;
        exp_bubble(0, 0, o, b);
        step();
        if (j == r) begin d = rv; break; end
        if (k == int'(TMO)) begin abort = 1; break; end
        k++; j++;
      end
    end
    dmem_gnt = 0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    e_ir = ir; e_o = o; e_d = (is_lw && !abort) ? d : 32'h0;
    e_stall = 0; e_err = abort; e_req = 0;
    step();
  endtask

  int          b_stall, b_req, b_err, b_ret;
  logic [31:0] rnd, ir;
  int          sel;

  initial begin
    reset = 0; in_ir = ADD_IR; in_O = 7; in_B = 3;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    e_ir = 0; e_o = 0; e_d = 0; e_stall = 0; e_err = 0; e_req = 0; e_we = 0;
    e_addr = 0; e_wdata = 0;
    chk_en = 1;
    step(); step();
    reset = 1;

    // T1: pass-through
    b_req = obs_req;
    run_op(ADD_IR, 32'd7, 32'd1, 0, 0, 0, 0);
    chk("t1_ir", obs_last_ir, 32'h0800_1234);
    chk("t1_noreq", obs_req - b_req, 0);

    // T2: lw with immediate gnt and rvalid
    b_stall = obs_stall;
    run_op(LW_IR, 32'h0000_1010, 32'h5, 0, 0, 1, 32'hCAFE_0001);
    chk("t2_stall_cycles", obs_stall - b_stall, 3);
    chk("t2_mw_D", obs_last_d, 32'hCAFE_0001);
    chk("t2_addr", {20'b0, obs_last_addr}, 32'h010);
    chk("t2_mw_ir", obs_last_ir, LW_IR);

    // T3: sw with gnt delayed 3 cycles, then a pass-through
    b_req = obs_req;
    run_op(SW_IR, 32'd5, 32'd9, 3, 0, 0, 0);
    chk("t3_req_cycles", obs_req - b_req, 4);
    chk("t3_wdata", obs_last_wdata, 32'd9);
    chk("t3_mw_D", obs_last_d, 32'h0);
    run_op(ADD_IR, 32'd11, 32'd0, 0, 0, 0, 0);
    chk("t3_next", obs_last_ir, ADD_IR);

    // T4: lw never granted
    b_req = obs_req; b_err = obs_err;
    run_op(LW_IR, 32'h20, 32'h0, 100, 0, 0, 0);
    chk("t4_req_cycles", obs_req - b_req, 5);
    chk("t4_err", obs_err - b_err, 1);
    chk("t4_mw_D", obs_last_d, 32'h0);
    run_op(ADD_IR, 32'd12, 32'd0, 0, 0, 0, 0);

    // T5: reset pulled low during WAIT
    in_ir = LW_IR; in_O = 32'h44; in_B = 0; dmem_gnt = 0; dmem_rvalid = 0;
    exp_bubble(0, 0, 32'h44, 0);
    step();
    dmem_gnt = 1;
    exp_bubble(1, 0, 32'h44, 0);
    step();
    dmem_gnt = 0;
    exp_bubble(0, 0, 32'h44, 0);
    #2;
    reset = 0;
    e_stall = 0;
    #1;
    chk("t5_async_stall", {31'b0, stall}, 0);
    chk("t5_async_req", {31'b0, dmem_req}, 0);
    chk("t5_async_ir", mw_ir, 0);
    step();
    reset = 1;
    b_err = obs_err;
    run_op(ADD_IR, 32'd13, 32'd0, 0, 0, 0, 0);
    chk("t5_pass", obs_last_ir, ADD_IR);
    chk("t5_no_err", obs_err - b_err, 0);

    // T6: lw immediately followed by sw
    b_ret = obs_retire; b_err = obs_err;
    run_op(LW_IR, 32'h30, 32'h0, 1, 1, 0, 0);
    run_op(SW_IR, 32'h31, 32'h77, 2, 0, 0, 0);
    chk("t6_retire", obs_retire - b_ret, 2);
    chk("t6_no_err", obs_err - b_err, 0);

    // Randomized mix of ops and memory latencies, some of which time out.
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      rnd = $urandom;
      if (sel < 4) ir = {LW, rnd[26:0]};
      else if (sel < 7) ir = {SW, rnd[26:0]};
      else if (sel == 9) ir = 32'h0;
      else begin
        ir = rnd;
        if (ir[31:27] == LW || ir[31:27] == SW) ir[31:27] = 5'b00000;
      end
      run_op(ir, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 4), 0, 0);
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
